// File: rtl/ex_pkg.sv
// EX-stage shared types: multiplier FSM states and default operand width.
package ex_pkg;

  localparam int MUL_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mul_state_t;

endpackage

// File: rtl/ex_mul_unit_if.sv
// Handshake bundle between EX control/ID-EX outputs and the multiplier.
interface ex_mul_unit_if
  import ex_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
);

  logic             start_i;
  logic             signed_i;
  logic             flush_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             stall_o;
  logic             busy_o;
  logic             valid_o;
  logic [WIDTH-1:0] result_lo_o;
  logic [WIDTH-1:0] result_hi_o;

  modport master (
    output start_i, signed_i, flush_i,
    output data1_i, data2_i,
    input  stall_o, busy_o, valid_o,
    input  result_lo_o, result_hi_o
  );

  modport slave (
    input  start_i, signed_i, flush_i,
    input  data1_i, data2_i,
    output stall_o, busy_o, valid_o,
    output result_lo_o, result_hi_o
  );

endinterface

// File: rtl/mul_negate.sv
// Conditional two's-complement negate: out = neg ? -in : in.
module mul_negate #(
  parameter int N = 64
) (
  input  logic [N-1:0] in_i,
  input  logic         neg_i,
  output logic [N-1:0] out_o
);

  assign out_o = neg_i ? (~in_i + N'(1)) : in_i;

endmodule

// File: rtl/ex_mul_unit.sv
// Iterative shift-add 32x32->64 multiplier in EX; stalls the front end.
// Optional MUL_EARLY_OUT_EN: finish as soon as the multiplier runs out of ones.
module ex_mul_unit
  import ex_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = 6
) (
  input logic          clk_i,
  input logic          rst_i,
  ex_mul_unit_if.slave mul
);

  localparam int PW = 2 * WIDTH;

  mul_state_t       state;
  logic [PW-1:0]    product;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic             neg;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;

  logic             sign1;
  logic             sign2;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [PW-1:0]    sum;
  logic [PW-1:0]    fin;
  logic [WIDTH-1:0] mplier_nx;
  logic             last;

  assign sign1 = mul.signed_i & mul.data1_i[WIDTH-1];
  assign sign2 = mul.signed_i & mul.data2_i[WIDTH-1];

  mul_negate #(.N(WIDTH)) u_mag1 (
    .in_i (mul.data1_i),
    .neg_i(sign1),
    .out_o(mag1)
  );

  mul_negate #(.N(WIDTH)) u_mag2 (
    .in_i (mul.data2_i),
    .neg_i(sign2),
    .out_o(mag2)
  );

  assign sum       = product + (mplier[0] ? mcand : '0);
  assign mplier_nx = mplier >> 1;

`ifdef MUL_EARLY_OUT_EN
  assign last = (cnt == '0) || (mplier_nx == '0);
`else
  assign last = (cnt == '0);
`endif

  mul_negate #(.N(PW)) u_fix (
    .in_i (sum),
    .neg_i(neg),
    .out_o(fin)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      res_lo  <= '0;
      res_hi  <= '0;
    end else if (mul.flush_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (mul.start_i) begin
          mcand   <= {{WIDTH{1'b0}}, mag1};
          mplier  <= mag2;
          neg     <= sign1 ^ sign2;
          product <= '0;
          cnt     <= CNT_W'(WIDTH - 1);
          state   <= BUSY;
        end
        BUSY: begin
          product <= last ? fin : sum;
          mcand   <= mcand << 1;
          mplier  <= mplier_nx;
          cnt     <= cnt - CNT_W'(1);
          if (last) begin
            res_lo <= fin[WIDTH-1:0];
            res_hi <= fin[PW-1:WIDTH];
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Release the front end in DONE so the next op lands in ID/EX.
  always_comb begin
    mul.stall_o = 1'b0;
    priority case (1'b1)
      mul.flush_i:    mul.stall_o = 1'b0;
      state == IDLE:  mul.stall_o = mul.start_i;
      state == BUSY:  mul.stall_o = 1'b1;
      default:        mul.stall_o = 1'b0;
    endcase
  end

  assign mul.busy_o      = (state != IDLE);
  assign mul.valid_o     = (state == DONE);
  assign mul.result_lo_o = res_lo;
  assign mul.result_hi_o = res_hi;

endmodule

// File: tb/tb_ex_mul_unit.sv
// Directed bench for ex_mul_unit: products, latency, stall, reset, flush.
module tb_ex_mul_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  ex_mul_unit_if #(.WIDTH(W)) bus ();

  ex_mul_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .mul  (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input logic [W-1:0] b, input bit s);
`ifdef MUL_EARLY_OUT_EN
    logic [W-1:0] m;
    int k;
    m = (s && b[W-1]) ? (~b + 1) : b;
    k = 0;
    for (int i = 0; i < W; i++)
      if (m[i]) k = i;
    return 2 + k;
`else
    return W + 1;
`endif
  endfunction

  function automatic logic [63:0] prod();
    return {bus.result_hi_o, bus.result_lo_o};
  endfunction

  task automatic run_op(input string tag, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit s,
                        input logic [63:0] expp);
    int  c;
    bit  st_ok;
    bus.data1_i  = a;
    bus.data2_i  = b;
    bus.signed_i = s;
    bus.start_i  = 1'b1;
    #1;
    c = 0;
    st_ok = 1'b1;
    while (!bus.valid_o && c < 100) begin
      if (!bus.stall_o) st_ok = 1'b0;
      tick();
      c++;
    end
    chk({tag, "_lat"}, 64'(c), 64'(exp_lat(b, s)));
    chk({tag, "_stall"}, 64'(st_ok), 64'd1);
    chk({tag, "_stall_done"}, 64'(bus.stall_o), 64'd0);
    chk({tag, "_prod"}, prod(), expp);
    bus.start_i = 1'b0;
    tick();
    chk({tag, "_pulse"}, 64'(bus.valid_o), 64'd0);
  endtask

  initial begin
    int  c;
    bit  seen;
    bus.start_i  = 1'b0;
    bus.signed_i = 1'b0;
    bus.flush_i  = 1'b0;
    bus.data1_i  = '0;
    bus.data2_i  = '0;
    tick();
    tick();
    chk("rst_stall", 64'(bus.stall_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_res", prod(), 64'd0);
    rst = 1'b0;
    tick();

    run_op("u7x6", 32'd7, 32'd6, 1'b0, 64'd42);
    run_op("uffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
           64'hFFFF_FFFE_0000_0001);
    run_op("sm3x5", 32'hFFFF_FFFD, 32'd5, 1'b1,
           64'hFFFF_FFFF_FFFF_FFF1);
    run_op("smin2", 32'h8000_0000, 32'h8000_0000, 1'b1,
           64'h4000_0000_0000_0000);
    run_op("sm7xm6", 32'hFFFF_FFF9, 32'hFFFF_FFFA, 1'b1, 64'd42);
    run_op("u_hi", 32'h8000_0000, 32'd3, 1'b0, 64'h1_8000_0000);
    run_op("uzero", 32'h1234_5678, 32'd0, 1'b0, 64'd0);
    run_op("u9x1", 32'd9, 32'd1, 1'b0, 64'd9);

    // Synchronous reset in the middle of BUSY
    bus.data1_i  = 32'd1000;
    bus.data2_i  = 32'd1000;
    bus.signed_i = 1'b0;
    bus.start_i  = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_busy", 64'(bus.busy_o), 64'd1);
    rst = 1'b1;
    bus.start_i = 1'b0;
    tick();
    chk("mrst_stall", 64'(bus.stall_o), 64'd0);
    chk("mrst_busy", 64'(bus.busy_o), 64'd0);
    chk("mrst_valid", 64'(bus.valid_o), 64'd0);
    chk("mrst_res", prod(), 64'd0);
    rst = 1'b0;
    tick();
    run_op("post_rst", 32'd12, 32'd11, 1'b0, 64'd132);

    // Flush in BUSY: no pulse, results kept
    bus.data1_i = 32'd100;
    bus.data2_i = 32'd3;
    bus.start_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.flush_i = 1'b1;
    bus.start_i = 1'b0;
    #1;
    chk("fl_stall_now", 64'(bus.stall_o), 64'd0);
    tick();
    bus.flush_i = 1'b0;
    #1;
    chk("fl_stall", 64'(bus.stall_o), 64'd0);
    chk("fl_busy", 64'(bus.busy_o), 64'd0);
    chk("fl_res", prod(), 64'd132);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.valid_o) seen = 1'b1;
      tick();
    end
    chk("fl_novalid", 64'(seen), 64'd0);

    // Back-to-back with start held through DONE
    bus.data1_i = 32'd2;
    bus.data2_i = 32'd3;
    bus.start_i = 1'b1;
    #1;
    c = 0;
    while (!bus.valid_o && c < 100) begin
      tick();
      c++;
    end
    chk("b2b_first", 64'(bus.valid_o), 64'd1);
    chk("b2b_p1", prod(), 64'd6);
    bus.data1_i = 32'd4;
    bus.data2_i = 32'd5;
    c = 0;
    tick();
    c++;
    while (!bus.valid_o && c < 100) begin
      tick();
      c++;
    end
    chk("b2b_gap", 64'(c), 64'(exp_lat(32'd5, 1'b0) + 1));
    chk("b2b_p2", prod(), 64'd20);
    bus.start_i = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
